mux_shift_serializer: RTL and testbench
=======================================

MUX_SHIFT_SERIALIZER -- requirements
Module: mux_shift_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 Port `clk`: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-004 Port `load_valid`: input, 1 bit, the parallel word on `din` is offered.
REQ-005 Port `load_ready`: output, 1 bit, the block can accept a word this cycle.
REQ-006 Port `din`: input, WIDTH bits, the parallel word to serialize.
REQ-007 Port `lsb_first`: input, 1 bit, bit order (1 = LSB first, 0 = MSB first); sampled only at load.
REQ-008 Port `sout`: output, 1 bit, the serial data bit.
REQ-009 Port `sout_valid`: output, 1 bit, `sout` carries a payload bit this cycle.
REQ-010 Port `busy`: output, 1 bit, high whenever the state is not IDLE.
REQ-011 Port `done`: output, 1 bit, one-cycle pulse after the last bit.

Function
REQ-012 The FSM SHALL have exactly three states:
- IDLE: `load_ready`=1.
- SHIFT: `sout_valid`=1.
- DONE: `done`=1.
REQ-013 In IDLE, `load_valid`=1 at a rising edge SHALL capture `din` into shreg, capture `lsb_first` into order_q, clear the bit counter to 0 and enter SHIFT.
REQ-014 In SHIFT, `sout` SHALL be shreg[0] when order_q=1 and shreg[WIDTH-1] when order_q=0.
REQ-015 Each SHIFT cycle SHALL shift shreg one place toward the output end, filling the vacated bit with 0, and increment the counter.
REQ-016 When the counter equals WIDTH-1 at a rising edge, the FSM SHALL enter DONE, so that `sout_valid` is high for exactly WIDTH consecutive cycles.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 Load latency: if the word is accepted at edge k, the first bit SHALL be valid in the cycle after edge k, and `done` SHALL be high in the cycle after the WIDTH-th bit.
REQ-019 `load_ready` SHALL be 0 in SHIFT and DONE; `load_valid` in those states SHALL be ignored, with no capture and no state change.
REQ-020 A change on `lsb_first` or `din` after load SHALL have no effect on the word in flight.
REQ-021 Outside SHIFT, `sout` SHALL be 0 and `sout_valid` SHALL be 0.
REQ-022 `done` SHALL be 0 outside DONE.
REQ-023 Each shreg bit's next value SHALL be chosen by a 4:1 mux with select mode[1:0]:
- 00 = hold
- 01 = shift toward LSB
- 10 = shift toward MSB
- 11 = parallel load
REQ-024 Mode SHALL be derived combinationally from the state, the load handshake and order_q.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap during a word.

Reset
REQ-026 While `rst`=1, the outputs and state SHALL be forced immediately, without waiting for `clk`:
- state = IDLE
- shreg = 0, counter = 0, order_q = 0
- `load_ready` = 1
- `sout`, `sout_valid`, `busy`, `done` = 0
REQ-027 Reset asserted mid-SHIFT SHALL abort the word; no `done` pulse SHALL follow.
REQ-028 After `rst` deasserts, the first rising edge SHALL already be able to accept a load.

Structure
REQ-029 A shared package SHALL hold:
- the state enumeration (IDLE, SHIFT, DONE);
- the mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD);
- the default WIDTH constant.
REQ-030 The per-bit selector SHALL be a sub-module `mux4to1_using_mux`, built from three instances of the existing `mux2to1` cell.
REQ-031 `mux_shift_serializer` SHALL instantiate `mux4to1_using_mux` WIDTH times.

Verification
REQ-032 MSB-first, WIDTH=8: load 8'hA5 with `lsb_first`=0 -> `sout` = 1,0,1,0,0,1,0,1 over 8 valid cycles, then `done`=1 for one cycle, then `load_ready`=1.
REQ-033 LSB-first: load 8'h0F with `lsb_first`=1 -> `sout` = 1,1,1,1,0,0,0,0; toggling `lsb_first` mid-word leaves the bit sequence unchanged.
REQ-034 Load during busy: hold `load_valid`=1 with `din`=8'hFF throughout an 8'h81 transfer -> output is 1,0,0,0,0,0,0,1; 8'hFF is accepted only in the IDLE cycle after DONE.
REQ-035 Reset mid-word: assert `rst` after the 3rd bit of 8'hC3 -> `sout_valid`, `busy` and `done` drop immediately and no `done` pulse follows; a fresh load of 8'h3C then streams correctly.
REQ-036 Back-to-back words: 8'h01 then 8'h80, `load_valid` held high -> exactly one idle cycle between the `done` pulse and the second word's first bit; 16 total valid bits match the expected sequence.
REQ-037 Parameter check, WIDTH=4: load 4'b1001 with `lsb_first`=0 -> 4 valid bits 1,0,0,1, with `done` 5 cycles after the accepting edge.

Source files
------------

// File: rtl/mux_shift_serializer_pkg.sv
// Shared types and constants for the mux-based shift serializer.
// States, per-bit mux select encodings and default word width.
package mux_shift_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/mux2to1.sv
// Basic 2:1 multiplexer cell.
// y follows b when sel is high, otherwise a.
module mux2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux4to1_using_mux.sv
// 4:1 multiplexer composed of three mux2to1 cells.
// sel selects d0..d3 in binary order.
module mux4to1_using_mux (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] sel,
  output logic       y
);

  logic lo;
  logic hi;

  mux2to1 u_lo (
    .a  (d0),
    .b  (d1),
    .sel(sel[0]),
    .y  (lo)
  );

  mux2to1 u_hi (
    .a  (d2),
    .b  (d3),
    .sel(sel[0]),
    .y  (hi)
  );

  mux2to1 u_out (
    .a  (lo),
    .b  (hi),
    .sel(sel[1]),
    .y  (y)
  );

endmodule

// File: rtl/mux_shift_serializer.sv
// Parallel-to-serial converter with selectable bit order.
// Each shift-register bit is fed by its own 4:1 mode mux.
module mux_shift_serializer
  import mux_shift_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             lsb_first,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] shr_v;
  logic [WIDTH-1:0] shl_v;
  logic [CW-1:0]    cnt;
  logic             order_q;
  logic [1:0]       mode;
  logic             last;

  assign last  = (cnt == LAST);
  assign shr_v = {1'b0, shreg[WIDTH-1:1]};
  assign shl_v = {shreg[WIDTH-2:0], 1'b0};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux4to1_using_mux u_mux (
      .d0 (shreg[i]),
      .d1 (shr_v[i]),
      .d2 (shl_v[i]),
      .d3 (din[i]),
      .sel(mode),
      .y  (shreg_n[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      order_q <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      if (state == IDLE && load_valid) begin
        cnt     <= '0;
        order_q <= lsb_first;
      end else if (state == SHIFT && !last) begin
        // saturate at the last bit so the count never wraps
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    mode       = MODE_HOLD;
    load_ready = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy       = 1'b0;
        load_ready = 1'b1;
        if (load_valid) begin
          mode    = MODE_LOAD;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = order_q ? shreg[0] : shreg[WIDTH-1];
        mode       = order_q ? MODE_SHR : MODE_SHL;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_shift_serializer.sv
// Scoreboard bench for mux_shift_serializer at WIDTH 8 and 4.
// Reference model predicts bit stream and handshake timing.
module tb_mux_shift_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] din = 8'h00;

  logic lr8, so8, sv8, b8, d8;
  logic lr4, so4, sv4, b4, d4;

  int n_checks = 0;
  int n_fail = 0;

  bit expq8[$];
  bit expq4[$];
  bit obs8[$];
  bit obs4[$];
  int rem8 = 0;
  int rem4 = 0;

  always #5 clk = ~clk;

  mux_shift_serializer #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(lr8),
    .din       (din),
    .lsb_first (lsb_first),
    .sout      (so8),
    .sout_valid(sv8),
    .busy      (b8),
    .done      (d8)
  );

  mux_shift_serializer #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(lr4),
    .din       (din[3:0]),
    .lsb_first (lsb_first),
    .sout      (so4),
    .sout_valid(sv4),
    .busy      (b4),
    .done      (d4)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: an accepted word occupies WIDTH shift cycles plus one done cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem8 <= 0;
      rem4 <= 0;
      expq8.delete();
      expq4.delete();
    end else begin
      if (rem8 == 0 && load_valid) begin
        for (int i = 0; i < 8; i++)
          expq8.push_back(din[lsb_first ? i : 7 - i]);
        rem8 <= 9;
      end else if (rem8 > 0) begin
        rem8 <= rem8 - 1;
      end
      if (rem4 == 0 && load_valid) begin
        for (int i = 0; i < 4; i++)
          expq4.push_back(din[lsb_first ? i : 3 - i]);
        rem4 <= 5;
      end else if (rem4 > 0) begin
        rem4 <= rem4 - 1;
      end
    end
  end

  task automatic flags(input string t, input logic lr, input logic sv,
                       input logic b, input logic d, input int rem);
    check({t, "_valid"}, sv, rem > 1);
    check({t, "_done"}, d, rem == 1);
    check({t, "_ready"}, lr, rem == 0);
    check({t, "_busy"}, b, rem != 0);
  endtask

  always @(negedge clk) begin
    flags("w8", lr8, sv8, b8, d8, rem8);
    flags("w4", lr4, sv4, b4, d4, rem4);
    if (sv8) begin
      obs8.push_back(so8);
      if (expq8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w8_extra_bit: got %0b expected none at %0t",
                 so8, $time);
      end else begin
        check("w8_sout", so8, expq8.pop_front());
      end
    end else begin
      check("w8_sout_idle", so8, 0);
    end
    if (sv4) begin
      obs4.push_back(so4);
      if (expq4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w4_extra_bit: got %0b expected none at %0t",
                 so4, $time);
      end else begin
        check("w4_sout", so4, expq4.pop_front());
      end
    end else begin
      check("w4_sout_idle", so4, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare a logged stream with a literal sequence, first bit at MSB.
  task automatic check_seq(input string name, input bit q[$],
                           input logic [15:0] bits, input int n);
    check({name, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      check({name, "_bit"}, q[i], bits[n-1-i]);
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", lr8, 1);
    check("rst_busy", b8, 0);
    check("rst_valid", sv8, 0);
    check("rst_done", d8, 0);
    check("rst_sout", so8, 0);
    rst = 1'b0;

    // MSB first, din and order scrambled while in flight
    obs8.delete();
    load_valid = 1'b1;
    din = 8'hA5;
    lsb_first = 1'b0;
    tick();
    load_valid = 1'b0;
    repeat (10) begin
      din = 8'($urandom);
      lsb_first = 1'($urandom);
      tick();
    end
    check_seq("msb_a5", obs8, 16'h00A5, 8);

    // LSB first with order toggling mid-word
    obs8.delete();
    load_valid = 1'b1;
    din = 8'h0F;
    lsb_first = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (10) begin
      lsb_first = ~lsb_first;
      tick();
    end
    check_seq("lsb_0f", obs8, 16'h00F0, 8);

    // load offered throughout a transfer
    obs8.delete();
    load_valid = 1'b1;
    din = 8'h81;
    lsb_first = 1'b0;
    tick();
    din = 8'hFF;
    repeat (10) tick();
    load_valid = 1'b0;
    repeat (10) tick();
    check_seq("busy_81ff", obs8, 16'h81FF, 16);

    // reset after the third bit
    obs8.delete();
    load_valid = 1'b1;
    din = 8'hC3;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    #6;
    rst = 1'b1;
    #1;
    check("midrst_valid", sv8, 0);
    check("midrst_busy", b8, 0);
    check("midrst_done", d8, 0);
    check("midrst_ready", lr8, 1);
    check_seq("midrst_c3", obs8, 16'h0006, 3);
    tick();
    rst = 1'b0;
    obs8.delete();
    load_valid = 1'b1;
    din = 8'h3C;
    tick();
    load_valid = 1'b0;
    repeat (10) tick();
    check_seq("after_rst_3c", obs8, 16'h003C, 8);

    // back-to-back words with load_valid held
    obs8.delete();
    load_valid = 1'b1;
    din = 8'h01;
    lsb_first = 1'b0;
    tick();
    din = 8'h80;
    repeat (10) tick();
    load_valid = 1'b0;
    repeat (10) tick();
    check_seq("b2b_0180", obs8, 16'h0180, 16);

    // narrow instance latency
    obs4.delete();
    load_valid = 1'b1;
    din = 8'h09;
    lsb_first = 1'b0;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    check("w4_done_lat", d4, 1);
    tick();
    check("w4_done_end", d4, 0);
    check("w4_ready_end", lr4, 1);
    check_seq("w4_1001", obs4, 16'h0009, 4);

    // random traffic with occasional resets
    repeat (400) begin
      load_valid = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      lsb_first = 1'($urandom);
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    load_valid = 1'b0;
    repeat (12) tick();
    check("drain8", expq8.size(), 0);
    check("drain4", expq4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
